// File: rtl/frv_leak_fence_ctrl.sv
// frv_leak_fence_ctrl
// Sequencer for the leakage-barrier fence. An accepted fence walks its ALCFG
// mask lowest bit first. For each selected target it raises one flush request
// carrying the value to write, and it steps the core PRNG once per completed
// flush.
//
// Build option: define FRV_LEAK_STRONG_EN for strong randomisation, where
// flush_data carries prng and prng_step pulses once per flush. Without it the
// block only zeroises: flush_data is 0, prng_step is 0 and prng is unused.
//
// Ports:
//   g_clk        clock, rising edge
//   g_resetn     synchronous active-low reset
//   fence_valid  fence presented by execute
//   fence_ready  idle; the fence is accepted on fence_valid & fence_ready
//   fence_cfg    ALCFG mask, sampled on accept
//   fence_done   one-cycle completion pulse
//   busy         a fence is in progress
//   flush_req    one-hot target currently being flushed
//   flush_data   value written into the flushed target
//   flush_ack    the target has completed its flush
//   prng_step    one-cycle pulse that advances the PRNG
//   prng         current PRNG value
module frv_leak_fence_ctrl #(
  parameter int NRES = 13,
  parameter int XL   = 31
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            fence_valid,
  output logic            fence_ready,
  input  logic [NRES-1:0] fence_cfg,
  output logic            fence_done,
  output logic            busy,
  output logic [NRES-1:0] flush_req,
  output logic [XL:0]     flush_data,
  input  logic            flush_ack,
  output logic            prng_step,
  input  logic [XL:0]     prng
);

`ifdef FRV_LEAK_STRONG_EN
  localparam logic STRONG_C = 1'b1;
`else
  localparam logic STRONG_C = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [NRES-1:0] mask_r, mask_s;
  logic            step_r, step_s;
  logic            present_s;
  logic [NRES-1:0] req_s;
  logic [NRES-1:0] rest_s;

  // Isolate the lowest set bit: bit 0 has the highest priority.
  function automatic logic [NRES-1:0] lowest_bit(input logic [NRES-1:0] m);
    return m & (~m + {{(NRES-1){1'b0}}, 1'b1});
  endfunction

  // While prng_step is high the PRNG has not yet updated. The next request
  // is held back for that cycle so each target sees a fresh, settled value.
  assign present_s = (state_r == FLUSH) && !step_r;
  assign req_s     = present_s ? lowest_bit(mask_r) : {NRES{1'b0}};
  assign rest_s    = mask_r & ~req_s;

  // State, mask and step-pulse registers.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_r <= IDLE;
      mask_r  <= {NRES{1'b0}};
      step_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      mask_r  <= mask_s;
      step_r  <= step_s;
    end
  end

  // Next-state logic: accept, walk the mask one ack at a time, then finish.
  always_comb begin
    state_s = state_r;
    mask_s  = mask_r;
    step_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (fence_valid) begin
          mask_s = fence_cfg;
          if (fence_cfg == {NRES{1'b0}}) begin
            state_s = DONE;
          end else begin
            state_s = FLUSH;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FLUSH: begin
        if (present_s && flush_ack) begin
          mask_s = rest_s;
          step_s = STRONG_C;
          if (rest_s == {NRES{1'b0}}) begin
            state_s = DONE;
          end else begin
            state_s = FLUSH;
          end
        end else begin
          state_s = FLUSH;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  assign fence_ready = (state_r == IDLE);
  assign busy        = (state_r != IDLE);
  assign fence_done  = (state_r == DONE);
  assign flush_req   = req_s;

`ifdef FRV_LEAK_STRONG_EN
  assign flush_data = present_s ? prng : {(XL+1){1'b0}};
  assign prng_step  = step_r;
`else
  logic unused_prng_s;
  assign unused_prng_s = ^prng;
  assign flush_data    = {(XL+1){1'b0}};
  assign prng_step     = 1'b0;
`endif

endmodule

// File: tb/tb_frv_leak_fence_ctrl.sv
// Self-checking bench for frv_leak_fence_ctrl. It drives an LFSR PRNG and
// predicts, per fence, the ordered list of targets, the data each one must
// carry, the number of PRNG steps and the cycle of fence_done.
module tb_frv_leak_fence_ctrl;

`ifdef FRV_LEAK_STRONG_EN
  localparam bit STRONG = 1'b1;
`else
  localparam bit STRONG = 1'b0;
`endif

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        fence_valid = 1'b0;
  logic        fence_ready;
  logic [12:0] fence_cfg = 13'h0000;
  logic        fence_done;
  logic        busy;
  logic [12:0] flush_req;
  logic [31:0] flush_data;
  logic        flush_ack = 1'b0;
  logic        prng_step;
  logic [31:0] prng;

  int total = 0;
  int bad   = 0;

  frv_leak_fence_ctrl #(.NRES(13), .XL(31)) dut (
    .g_clk       (g_clk),
    .g_resetn    (g_resetn),
    .fence_valid (fence_valid),
    .fence_ready (fence_ready),
    .fence_cfg   (fence_cfg),
    .fence_done  (fence_done),
    .busy        (busy),
    .flush_req   (flush_req),
    .flush_data  (flush_data),
    .flush_ack   (flush_ack),
    .prng_step   (prng_step),
    .prng        (prng)
  );

  always #5 g_clk = ~g_clk;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h80200003 : 32'h00000000);
  endfunction

  // Core PRNG stand-in: advances only on prng_step.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) prng <= 32'hABCDEF37;
    else if (prng_step) prng <= lfsr_next(prng);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One complete fence. fixed_dly < 0 picks a random ack wait (0..3) per target.
  task automatic run_fence(input logic [12:0] cfg, input int fixed_dly);
    int          dly [13];
    logic [12:0] exp_req [13];
    logic [31:0] exp_data [13];
    int          n, exp_done, qi, wc, steps;
    bit          done_seen;
    logic [31:0] v;
    n = 0;
    v = prng;
    for (int i = 0; i < 13; i++) begin
      if (cfg[i]) begin
        exp_req[n]  = 13'h0001 << i;
        exp_data[n] = STRONG ? v : 32'h00000000;
        v = lfsr_next(v);
        dly[n] = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
        n++;
      end
    end
    exp_done = 1;
    for (int j = 0; j < n; j++) exp_done += dly[j] + 1;
    if (STRONG && n > 0) exp_done += n - 1;

    @(negedge g_clk);
    check("ready_before", {31'd0, fence_ready}, 32'd1);
    fence_valid = 1'b1;
    fence_cfg   = cfg;
    qi = 0; wc = 0; steps = 0; done_seen = 1'b0;
    for (int c = 1; c <= 300 && !done_seen; c++) begin
      @(negedge g_clk);
      // requester keeps valid high with a different mask while busy
      fence_cfg = 13'($urandom);
      if (prng_step) steps++;
      if (flush_req != 13'h0000) begin
        if (qi < n) begin
          check("flush_req", {19'd0, flush_req}, {19'd0, exp_req[qi]});
          check("flush_data", flush_data, exp_data[qi]);
          if (wc >= dly[qi]) begin
            flush_ack = 1'b1; qi++; wc = 0;
          end else begin
            flush_ack = 1'b0; wc++;
          end
        end else begin
          check("extra_req", {19'd0, flush_req}, 32'd0);
          flush_ack = 1'b1;
        end
      end else begin
        flush_ack = 1'($urandom_range(0, 1));
      end
      if (fence_done) begin
        done_seen = 1'b1;
        check("done_cycle", c, exp_done);
        fence_valid = 1'b0;
      end else begin
        check("busy_notready", {30'd0, busy, fence_ready}, 32'd2);
      end
    end
    if (!done_seen) check("done_timeout", 32'd0, 32'd1);
    flush_ack = 1'b0;
    fence_valid = 1'b0;
    @(negedge g_clk);
    check("idle_after", {28'd0, fence_ready, busy, fence_done, prng_step}, 32'h8);
    check("targets", qi, n);
    check("prng_steps", steps, STRONG ? n : 0);
  endtask

  initial begin
    g_resetn = 1'b0;
    repeat (3) @(negedge g_clk);
    check("rst_ctrl", {28'd0, fence_ready, busy, fence_done, prng_step}, 32'h8);
    check("rst_req", {19'd0, flush_req}, 32'd0);
    check("rst_data", flush_data, 32'd0);
    g_resetn = 1'b1;

    run_fence(13'h0000, 0);
    run_fence(13'h0005, 0);
    run_fence(13'h1000, 5);
    run_fence(13'h1FFF, -1);
    for (int k = 0; k < 20; k++) run_fence(13'($urandom), -1);

    // reset in the middle of a flush: the sequence is abandoned
    @(negedge g_clk);
    fence_valid = 1'b1;
    fence_cfg   = 13'h1FFF;
    flush_ack   = 1'b0;
    repeat (3) @(negedge g_clk);
    check("mid_req", {19'd0, flush_req}, 32'h1);
    g_resetn    = 1'b0;
    fence_valid = 1'b0;
    flush_ack   = 1'b1;
    @(negedge g_clk);
    check("rst_mid_req", {19'd0, flush_req}, 32'd0);
    check("rst_mid_ctrl", {28'd0, fence_ready, busy, fence_done, prng_step}, 32'h8);
    repeat (2) begin
      @(negedge g_clk);
      check("rst_hold_done", {31'd0, fence_done}, 32'd0);
    end
    g_resetn  = 1'b1;
    flush_ack = 1'b0;
    @(negedge g_clk);
    check("rst_release", {28'd0, fence_ready, busy, fence_done, prng_step}, 32'h8);

    run_fence(13'h0003, 0);
    run_fence(13'h0003, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
